// File: rtl/param_nibbler_pkg.sv
// Shared definitions for the slice-serial ALU: opcodes, FSM states and the
// default slice width.
package param_nibbler_pkg;

  // Default slice width in bits; one slice is processed per clock.
  localparam int NIBBLER_NBITS_DEFAULT = 4;

  // Operand and result width.
  localparam int NIBBLER_WORD_W = 32;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLT  = 3'd5,
    OP_SLTU = 3'd6,
    OP_RSVD = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Ops that run as a - b (inverted b, carry-in 1) and report compare flags.
  function automatic logic op_uses_sub(input alu_op_e op);
    return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
  endfunction

endpackage

// File: rtl/param_SubwordALUSlice.sv
// Combinational P_NBITS-wide ALU slice: add/subtract with carry in/out plus
// bitwise logic ops. o_zero flags an all-zero slice result.
module param_SubwordALUSlice
  import param_nibbler_pkg::*;
#(
  parameter int P_NBITS = NIBBLER_NBITS_DEFAULT
) (
  input  logic [P_NBITS-1:0] i_a,
  input  logic [P_NBITS-1:0] i_b,
  input  alu_op_e            i_op,
  input  logic               i_cin,
  output logic [P_NBITS-1:0] o_res,
  output logic               o_cout,
  output logic               o_zero
);

  logic [P_NBITS-1:0] w_b_eff;
  logic [P_NBITS:0]   w_sum;

  // Slice result: subtract-type ops add the inverted b operand.
  always_comb begin
    w_b_eff = op_uses_sub(i_op) ? ~i_b : i_b;
    w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{P_NBITS{1'b0}}, i_cin};
    o_res   = '0;
    o_cout  = 1'b0;
    case (i_op)
      OP_ADD, OP_SUB, OP_SLT, OP_SLTU: begin
        o_res  = w_sum[P_NBITS-1:0];
        o_cout = w_sum[P_NBITS];
      end
      OP_AND:  o_res = i_a & i_b;
      OP_OR:   o_res = i_a | i_b;
      OP_XOR:  o_res = i_a ^ i_b;
      default: o_res = '0;
    endcase
    o_zero = ~|o_res;
  end

endmodule

// File: rtl/param_subword_alu_seq.sv
// Slice-serial 32-bit ALU. An accepted request is processed one P_NBITS slice
// per cycle (LSB first) through a single shared slice; results and compare
// flags are finalised in the first DONE cycle and held until consumed.
module param_subword_alu_seq
  import param_nibbler_pkg::*;
#(
  parameter int P_NBITS   = NIBBLER_NBITS_DEFAULT,
  parameter int C_N_OFF   = 32 / P_NBITS,
  parameter int C_OFFBITS = (C_N_OFF > 1) ? $clog2(C_N_OFF) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_val,
  output logic                 req_rdy,
  input  logic [2:0]           req_op,
  input  logic [31:0]          req_a,
  input  logic [31:0]          req_b,
  output logic                 resp_val,
  input  logic                 resp_rdy,
  output logic [31:0]          resp_data,
  output logic                 resp_eq,
  output logic                 resp_lt,
  output logic                 resp_ltu,
  output logic [C_OFFBITS-1:0] uop_off
);

  localparam logic [C_OFFBITS-1:0] C_LAST_OFF = C_OFFBITS'(C_N_OFF - 1);

  alu_state_e           r_state;
  alu_state_e           w_state_next;
  alu_op_e              r_op;
  logic [31:0]          r_a;
  logic [31:0]          r_b;
  logic [31:0]          r_res;
  logic                 r_a_msb;
  logic                 r_b_msb;
  logic                 r_carry;
  logic                 r_zero;
  logic [C_OFFBITS-1:0] r_off;
  logic                 r_resp_val;
  logic [31:0]          r_resp_data;
  logic                 r_eq;
  logic                 r_lt;
  logic                 r_ltu;

  logic [P_NBITS-1:0]   w_slice_res;
  logic                 w_slice_cout;
  logic                 w_slice_zero;
  logic [31:0]          w_a_shift;
  logic [31:0]          w_b_shift;
  logic [31:0]          w_res_shift;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_consume;
  logic                 w_ovf;
  logic                 w_lt;
  logic                 w_ltu;
  logic                 w_eq;

  param_SubwordALUSlice #(
    .P_NBITS (P_NBITS)
  ) u_slice (
    .i_a    (r_a[P_NBITS-1:0]),
    .i_b    (r_b[P_NBITS-1:0]),
    .i_op   (r_op),
    .i_cin  (r_carry),
    .o_res  (w_slice_res),
    .o_cout (w_slice_cout),
    .o_zero (w_slice_zero)
  );

  // Operands shift down one slice per cycle; results enter at the top so the
  // first (LSB) slice lands at bit 0 after the last shift.
  if (C_N_OFF == 1) begin : g_single
    assign w_a_shift   = '0;
    assign w_b_shift   = '0;
    assign w_res_shift = w_slice_res;
  end else begin : g_multi
    assign w_a_shift   = {{P_NBITS{1'b0}}, r_a[31:P_NBITS]};
    assign w_b_shift   = {{P_NBITS{1'b0}}, r_b[31:P_NBITS]};
    assign w_res_shift = {w_slice_res, r_res[31:P_NBITS]};
  end

  assign w_accept  = (r_state == ST_IDLE) && req_val;
  assign w_last    = (r_off == C_LAST_OFF);
  assign w_consume = r_resp_val && resp_rdy;

  // Signed overflow of a - b: operand signs differ and result sign differs
  // from a. The original sign bits are kept since the shift registers lose them.
  assign w_ovf = (r_a_msb ^ r_b_msb) & (r_res[31] ^ r_a_msb);
  assign w_lt  = r_res[31] ^ w_ovf;
  assign w_ltu = ~r_carry;
  assign w_eq  = r_zero;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_state_next = ST_EXEC;
      ST_EXEC: if (w_last)    w_state_next = ST_DONE;
      ST_DONE: if (w_consume) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs; resp_val waits for the finalise cycle at the start of DONE.
  always_comb begin
    req_rdy  = (r_state == ST_IDLE);
    resp_val = (r_state == ST_DONE) && r_resp_val;
    uop_off  = (r_state == ST_EXEC) ? r_off : '0;
  end

  // Datapath: capture on accept, one slice per EXEC cycle, finalise in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op        <= OP_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_a_msb     <= 1'b0;
      r_b_msb     <= 1'b0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_off       <= '0;
      r_resp_val  <= 1'b0;
      r_resp_data <= '0;
      r_eq        <= 1'b0;
      r_lt        <= 1'b0;
      r_ltu       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= alu_op_e'(req_op);
            r_a     <= req_a;
            r_b     <= req_b;
            r_a_msb <= req_a[31];
            r_b_msb <= req_b[31];
            r_res   <= '0;
            r_carry <= op_uses_sub(alu_op_e'(req_op));
            r_zero  <= 1'b1;
            r_off   <= '0;
          end
        end
        ST_EXEC: begin
          r_a     <= w_a_shift;
          r_b     <= w_b_shift;
          r_res   <= w_res_shift;
          r_carry <= w_slice_cout;
          r_zero  <= r_zero & w_slice_zero;
          r_off   <= w_last ? '0 : r_off + 1'b1;
        end
        ST_DONE: begin
          if (!r_resp_val) begin
            r_resp_val <= 1'b1;
            case (r_op)
              OP_SUB: begin
                r_resp_data <= r_res;
                r_eq        <= w_eq;
                r_lt        <= w_lt;
                r_ltu       <= w_ltu;
              end
              OP_SLT: begin
                r_resp_data <= {31'b0, w_lt};
                r_eq        <= w_eq;
                r_lt        <= w_lt;
                r_ltu       <= w_ltu;
              end
              OP_SLTU: begin
                r_resp_data <= {31'b0, w_ltu};
                r_eq        <= w_eq;
                r_lt        <= w_lt;
                r_ltu       <= w_ltu;
              end
              OP_RSVD: begin
                r_resp_data <= '0;
                r_eq        <= 1'b0;
                r_lt        <= 1'b0;
                r_ltu       <= 1'b0;
              end
              default: begin
                r_resp_data <= r_res;
                r_eq        <= 1'b0;
                r_lt        <= 1'b0;
                r_ltu       <= 1'b0;
              end
            endcase
          end else if (resp_rdy) begin
            r_resp_val <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_data = r_resp_data;
  assign resp_eq   = r_eq;
  assign resp_lt   = r_lt;
  assign resp_ltu  = r_ltu;

endmodule

// File: tb/tb_param_subword_alu_seq.sv
// Scoreboard bench for the slice-serial ALU at slice widths 4, 1 and 32.
module tb_param_subword_alu_seq;

  typedef struct {
    logic [31:0] data;
    logic        eq;
    logic        lt;
    logic        ltu;
    int          lat;
  } exp_t;

  localparam logic [2:0] T_ADD  = 3'd0;
  localparam logic [2:0] T_SUB  = 3'd1;
  localparam logic [2:0] T_AND  = 3'd2;
  localparam logic [2:0] T_OR   = 3'd3;
  localparam logic [2:0] T_XOR  = 3'd4;
  localparam logic [2:0] T_SLT  = 3'd5;
  localparam logic [2:0] T_SLTU = 3'd6;
  localparam logic [2:0] T_RSVD = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_val  [3];
  logic        resp_rdy [3];
  logic [2:0]  req_op   [3];
  logic [31:0] req_a    [3];
  logic [31:0] req_b    [3];
  logic        req_rdy_w  [3];
  logic        resp_val_w [3];
  logic        eq_w  [3];
  logic        lt_w  [3];
  logic        ltu_w [3];
  logic [31:0] data_w [3];
  logic [4:0]  uop_w  [3];

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int NB   = (gi == 0) ? 4 : ((gi == 1) ? 1 : 32);
    localparam int NOFF = 32 / NB;
    localparam int OB   = (NOFF > 1) ? $clog2(NOFF) : 1;
    logic [OB-1:0] uop_loc;

    param_subword_alu_seq #(.P_NBITS(NB)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_val   (req_val[gi]),
      .req_rdy   (req_rdy_w[gi]),
      .req_op    (req_op[gi]),
      .req_a     (req_a[gi]),
      .req_b     (req_b[gi]),
      .resp_val  (resp_val_w[gi]),
      .resp_rdy  (resp_rdy[gi]),
      .resp_data (data_w[gi]),
      .resp_eq   (eq_w[gi]),
      .resp_lt   (lt_w[gi]),
      .resp_ltu  (ltu_w[gi]),
      .uop_off   (uop_loc)
    );
    assign uop_w[gi] = 5'(uop_loc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nb_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 32);
  endfunction

  // Reference model built from plain 32-bit arithmetic and compares.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic eq, lt, ltu;
    eq  = (a == b);
    ltu = (a < b);
    lt  = ($signed(a) < $signed(b));
    e.data = '0; e.eq = 1'b0; e.lt = 1'b0; e.ltu = 1'b0; e.lat = 0;
    case (op)
      T_ADD:  e.data = a + b;
      T_SUB:  begin e.data = a - b;         e.eq = eq; e.lt = lt; e.ltu = ltu; end
      T_AND:  e.data = a & b;
      T_OR:   e.data = a | b;
      T_XOR:  e.data = a ^ b;
      T_SLT:  begin e.data = {31'b0, lt};   e.eq = eq; e.lt = lt; e.ltu = ltu; end
      T_SLTU: begin e.data = {31'b0, ltu};  e.eq = eq; e.lt = lt; e.ltu = ltu; end
      default: e.data = '0;
    endcase
    return e;
  endfunction

  task automatic wait_idle(input int k);
    int w = 0;
    while (!req_rdy_w[k] && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("idle_before_req", 32'(req_rdy_w[k]), 32'd1);
  endtask

  // Issue one op on instance k; hold>0 keeps resp_rdy low that many cycles in DONE.
  task automatic run_op(input int k, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    exp_t e;
    exp_t g;
    int   cyc;
    int   n;
    bit   seen;
    n = 32 / nb_of(k);
    wait_idle(k);
    e = model(op, a, b);
    e.lat = n + 1;
    sb.push_back(e);
    resp_rdy[k] = (hold == 0);
    req_op[k] = op; req_a[k] = a; req_b[k] = b; req_val[k] = 1'b1;
    @(negedge clk);
    chk("rdy_low_after_accept", 32'(req_rdy_w[k]), 32'd0);
    req_val[k] = 1'b0;
    req_a[k] = $urandom; req_b[k] = $urandom; req_op[k] = 3'($urandom);
    cyc = 0;
    seen = 1'b0;
    while (cyc <= 40 && !seen) begin
      if (resp_val_w[k]) begin
        seen = 1'b1;
      end else begin
        chk("uop_off", 32'(uop_w[k]), (cyc < n) ? 32'(cyc) : 32'd0);
        @(negedge clk);
        cyc++;
      end
    end
    g = sb.pop_front();
    if (!seen) begin
      chk("resp_timeout", 32'd0, 32'd1);
    end else begin
      chk("latency",   32'(cyc),          32'(g.lat));
      chk("resp_data", data_w[k],         g.data);
      chk("resp_eq",   32'(eq_w[k]),      32'(g.eq));
      chk("resp_lt",   32'(lt_w[k]),      32'(g.lt));
      chk("resp_ltu",  32'(ltu_w[k]),     32'(g.ltu));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("bp_data_stable", data_w[k],            g.data);
        chk("bp_req_rdy",     32'(req_rdy_w[k]),    32'd0);
        chk("bp_resp_val",    32'(resp_val_w[k]),   32'd1);
      end
      resp_rdy[k] = 1'b1;
      @(negedge clk);
      chk("post_consume_rdy", 32'(req_rdy_w[k]),  32'd1);
      chk("post_consume_val", 32'(resp_val_w[k]), 32'd0);
    end
    $display("dut%0d nb=%0d op=%0d a=%h b=%h -> data=%h eq=%0d lt=%0d ltu=%0d lat=%0d exp=%h",
             k, nb_of(k), op, a, b, data_w[k], eq_w[k], lt_w[k], ltu_w[k], cyc, g.data);
  endtask

  task automatic reset_mid_exec();
    int  cyc = 0;
    bit  seen = 1'b0;
    wait_idle(0);
    resp_rdy[0] = 1'b1;
    req_op[0] = T_ADD; req_a[0] = 32'h1357_9BDF; req_b[0] = 32'h0246_8ACE; req_val[0] = 1'b1;
    @(negedge clk);
    req_val[0] = 1'b0;
    while (uop_w[0] != 5'd3 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_at_uop3", 32'(uop_w[0]), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_req_rdy",   32'(req_rdy_w[0]),  32'd1);
    chk("rst_resp_val",  32'(resp_val_w[0]), 32'd0);
    chk("rst_uop_off",   32'(uop_w[0]),      32'd0);
    chk("rst_resp_data", data_w[0],          32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp_val_w[0]) seen = 1'b1;
    end
    chk("rst_no_resp", 32'(seen), 32'd0);
    $display("dut0 reset at uop_off=3 -> aborted, resp_val seen=%0d", seen);
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_val[k] = 1'b0; resp_rdy[k] = 1'b1; req_op[k] = '0; req_a[k] = '0; req_b[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_req_rdy",  32'(req_rdy_w[k]),  32'd1);
      chk("reset_resp_val", 32'(resp_val_w[k]), 32'd0);
      chk("reset_data",     data_w[k],          32'd0);
      chk("reset_flags",    {29'd0, eq_w[k], lt_w[k], ltu_w[k]}, 32'd0);
      chk("reset_uop_off",  32'(uop_w[k]),      32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      run_op(k, T_ADD,  32'h0000_000F, 32'h0000_0001, 0);
      run_op(k, T_SUB,  32'h0000_0000, 32'h0000_0001, 0);
      run_op(k, T_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 0);
      run_op(k, T_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 0);
      run_op(k, T_SLT,  32'h1234_5678, 32'h1234_5678, 0);
      run_op(k, T_SUB,  32'h1234_5678, 32'h1234_5678, 0);
      run_op(k, T_SLT,  32'h8000_0000, 32'h0000_0001, 0);
      run_op(k, T_SLTU, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    end

    run_op(0, T_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op(0, T_AND,  32'hF0F0_1234, 32'hFF00_FF00, 0);
    run_op(0, T_OR,   32'h0F0F_0000, 32'h00F0_00F0, 0);
    run_op(0, T_RSVD, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    run_op(0, T_SLT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(0, T_SUB,  32'h8000_0000, 32'h0000_0001, 0);
    for (int i = 0; i < 6; i++) begin
      run_op(i % 3, 3'($urandom_range(0, 7)), $urandom, $urandom, 0);
    end

    run_op(0, T_SUB, 32'h0001_0000, 32'h0000_FFFF, 5);

    reset_mid_exec();
    run_op(0, T_XOR, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_subword_alu_seq.md
PARAM_SUBWORD_ALU_SEQ -- requirements
Module: param_subword_alu_seq

Interface
REQ-001 SHALL have parameter P_NBITS, default 4, slice width in bits; legal values 1, 2, 4, 8, 16, 32.
REQ-002 SHALL have parameter C_N_OFF, default 32/P_NBITS, number of slices (micro-ops) per operation.
REQ-003 SHALL have parameter C_OFFBITS, default max(1,$clog2(C_N_OFF)), slice-index width.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port req_val  in  1  request valid.
REQ-007 SHALL have port req_rdy  out  1  block accepts a request this cycle.
REQ-008 SHALL have port req_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 reserved.
REQ-009 SHALL have ports req_a and req_b  in  32 each  operands.
REQ-010 SHALL have port resp_val  out  1  result valid.
REQ-011 SHALL have port resp_rdy  in  1  consumer accepts result.
REQ-012 SHALL have port resp_data  out  32  result.
REQ-013 SHALL have ports resp_eq, resp_lt, resp_ltu  out  1 each  compare flags of a vs b.
REQ-014 SHALL have port uop_off  out  C_OFFBITS  index of slice processed this cycle (0 outside EXEC).

Function
REQ-015 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; req_rdy=1 only in IDLE, resp_val=1 only in DONE.
REQ-016 SHALL capture req_op, req_a, req_b and enter EXEC on the edge where req_val && req_rdy.
REQ-017 SHALL in EXEC process one P_NBITS slice per cycle, LSB slice first, uop_off counting 0..C_N_OFF-1.
REQ-018 SHALL leave EXEC after the cycle with uop_off == C_N_OFF-1; resp_val rises exactly C_N_OFF+1 cycles after the accept edge.
REQ-019 SHALL hold resp_data and flags stable in DONE until resp_val && resp_rdy, then return to IDLE next edge.
REQ-020 SHALL not accept a new request in the same cycle a response is consumed (no overlap; one op in flight).
REQ-021 SHALL for ADD use carry-in 0 at slice 0; for SUB/SLT/SLTU use ~b with carry-in 1; carry propagated between slices by a carry register.
REQ-022 SHALL wrap arithmetic modulo 2^32; final carry-out discarded except for flags.
REQ-023 SHALL for SUB/SLT/SLTU set resp_eq = all difference slices zero, resp_ltu = ~final carry, resp_lt = N xor V of the 32-bit difference.
REQ-024 SHALL for SLT/SLTU drive resp_data = {31'b0, resp_lt} / {31'b0, resp_ltu}.
REQ-025 SHALL drive all flags 0 for ADD/AND/OR/XOR and reserved op; reserved op SHALL produce resp_data 0 with normal latency.
REQ-026 SHALL ignore req_* input changes after the accept edge.
REQ-027 SHALL with P_NBITS=32 complete in one EXEC cycle (C_N_OFF=1), behaviour otherwise identical.

Reset
REQ-028 SHALL on reset enter IDLE: req_rdy=1, resp_val=0, resp_data=0, all flags 0, uop_off=0, carry and zero registers cleared.
REQ-029 SHALL on reset asserted mid-EXEC or in DONE abort the operation with no response produced.
REQ-030 SHALL give reset priority over every simultaneous handshake event.

Structure
REQ-031 SHALL take opcode encodings and P_NBITS default from shared package param_nibbler_pkg.
REQ-032 SHALL instantiate one combinational sub-module param_SubwordALUSlice (P_NBITS-wide add/sub/logic with carry in/out, zero out).
REQ-033 SHALL keep the FSM, slice counter, operand shift registers and result accumulator in the top module.

Verification
REQ-034 SHALL verify ADD, P_NBITS=4: a=0x0000_000F, b=0x0000_0001 -> resp_data=0x0000_0010, resp_val 9 cycles after accept, flags 0.
REQ-035 SHALL verify SUB wrap: a=0, b=1 -> resp_data=0xFFFF_FFFF, resp_eq=0, resp_ltu=1, resp_lt=1.
REQ-036 SHALL verify SLT vs SLTU: a=0xFFFF_FFFF, b=1 -> SLT resp_data=1, SLTU resp_data=0; a=b=0x1234_5678 -> resp_eq=1.
REQ-037 SHALL verify backpressure: resp_rdy=0 for 5 cycles in DONE -> resp_data stable, req_rdy=0, then IDLE one edge after resp_rdy=1.
REQ-038 SHALL verify reset at uop_off=3 -> next cycle IDLE, resp_val never asserted, subsequent XOR 0xAAAA_AAAA^0xFFFF_FFFF=0x5555_5555.
REQ-039 SHALL repeat REQ-034..036 for P_NBITS=1 (latency 33) and P_NBITS=32 (latency 2).
